// File: rtl/lsu_split_ctrl_pkg.sv
// Shared core types for the load/store unit: access sizes, FSM states,
// ALU operand-B selects and byte-enable / store-data helpers.
package lsu_split_ctrl_pkg;

    typedef enum logic [1:0] {
        WORD = 2'b00,
        HALF = 2'b01,
        BYTE = 2'b10
    } data_type_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID
    } lsu_state_e;

    typedef enum logic {
        OP_B_REG_B,
        OP_B_IMM
    } op_b_sel_e;

    typedef enum logic [2:0] {
        IMM_B_I,
        IMM_B_S,
        IMM_B_B,
        IMM_B_U,
        IMM_B_J,
        IMM_B_INCR_PC,
        IMM_B_INCR_ADDR
    } imm_b_sel_e;

    function automatic logic is_split(input data_type_e t,
                                      input logic [1:0] off);
        return ((t == WORD) && (off != 2'd0)) ||
               ((t == HALF) && (off == 2'd3));
    endfunction

    // Phase 2 covers whatever bytes spilled past the first word.
    function automatic logic [3:0] be_calc(input data_type_e t,
                                           input logic [1:0] off,
                                           input logic p2);
        logic [3:0] be;
        be = 4'b0000;
        unique case (t)
            WORD:    be = p2 ? ~(4'b1111 << off) : (4'b1111 << off);
            HALF:    be = p2 ? 4'b0001 : (4'b0011 << off);
            BYTE:    be = 4'b0001 << off;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_rot(input logic [31:0] w,
                                              input logic [1:0] off);
        logic [31:0] r;
        r = w;
        unique case (off)
            2'd1:    r = {w[23:0], w[31:24]};
            2'd2:    r = {w[15:0], w[31:16]};
            2'd3:    r = {w[7:0],  w[31:8]};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_split_ctrl_rdata_align.sv
// Load data alignment: merges the two halves of a split access, then
// truncates to the access size and zero- or sign-extends.
module lsu_rdata_align
    import lsu_split_ctrl_pkg::*;
(
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  data_type_e  dtype,
    input  logic        sign_ext,
    input  logic        split,
    output logic [31:0] result
);

    logic [4:0]  sh;
    logic [31:0] word;

    assign sh = {off, 3'b000};

    always_comb begin
        word   = rdata >> sh;
        result = word;
        if (split) begin
            word = (rdata_lo >> sh) | (rdata << (6'd32 - {1'b0, sh}));
        end
        unique case (1'b1)
            (dtype == BYTE): result = {{24{sign_ext & word[7]}}, word[7:0]};
            (dtype == HALF): result = {{16{sign_ext & word[15]}}, word[15:0]};
            default:         result = word;
        endcase
    end

endmodule

// File: rtl/lsu_split_ctrl.sv
// LSU bus controller: issues one or two word-aligned bus transactions per
// EX-stage request and returns a registered, aligned completion.
module lsu_split_ctrl
    import lsu_split_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  data_type_e  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        lsu_addr_incr_req_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_resp_valid_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic        lsu_busy_o
);

    lsu_state_e  state_q;
    logic        split_q;
    logic [1:0]  off_q;
    data_type_e  type_q;
    logic        we_q;
    logic        sign_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_out_q;
    logic        resp_q;
    logic        load_err_q;
    logic        store_err_q;
    logic        hold_q;

    logic        idle;
    logic        issue;
    logic [1:0]  cur_off;
    data_type_e  cur_type;
    logic        cur_we;
    logic [31:0] aligned;

    assign idle     = (state_q == IDLE);
    // hold_q blocks issue in the reset-release and response cycles.
    assign issue    = idle & lsu_req_i & ~hold_q;
    assign cur_off  = idle ? adder_result_ex_i[1:0] : off_q;
    assign cur_type = idle ? lsu_type_i : type_q;
    assign cur_we   = idle ? lsu_we_i : we_q;

    assign data_req_o = issue
                      | (state_q == WAIT_GNT_MIS)
                      | (state_q == WAIT_GNT);
    assign data_addr_o  = {adder_result_ex_i[31:2], 2'b00};
    assign data_we_o    = cur_we;
    assign data_be_o    = be_calc(cur_type, cur_off, split_q);
    assign data_wdata_o = wdata_rot(lsu_wdata_i, cur_off);

    assign lsu_addr_incr_req_o = split_q & (state_q == WAIT_GNT);
    assign lsu_busy_o          = ~idle;
    assign lsu_resp_valid_o    = resp_q;
    assign load_err_o          = load_err_q;
    assign store_err_o         = store_err_q;
    assign lsu_rdata_o         = rdata_out_q;

    lsu_rdata_align u_align (
        .rdata_lo (rdata_q),
        .rdata    (data_rdata_i),
        .off      (off_q),
        .dtype    (type_q),
        .sign_ext (sign_q),
        .split    (split_q),
        .result   (aligned)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            split_q     <= 1'b0;
            off_q       <= 2'd0;
            type_q      <= WORD;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            rdata_q     <= 32'd0;
            rdata_out_q <= 32'd0;
            resp_q      <= 1'b0;
            load_err_q  <= 1'b0;
            store_err_q <= 1'b0;
            hold_q      <= 1'b1;
        end else begin
            resp_q      <= 1'b0;
            load_err_q  <= 1'b0;
            store_err_q <= 1'b0;
            hold_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        off_q   <= adder_result_ex_i[1:0];
                        type_q  <= lsu_type_i;
                        we_q    <= lsu_we_i;
                        sign_q  <= lsu_sign_ext_i;
                        split_q <= 1'b0;
                        if (is_split(lsu_type_i, adder_result_ex_i[1:0]))
                            state_q <= data_gnt_i ? WAIT_RVALID_MIS
                                                  : WAIT_GNT_MIS;
                        else
                            state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
                WAIT_GNT_MIS: begin
                    if (data_gnt_i) state_q <= WAIT_RVALID_MIS;
                end
                WAIT_RVALID_MIS: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            resp_q      <= 1'b1;
                            load_err_q  <= ~we_q;
                            store_err_q <= we_q;
                            hold_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            rdata_q <= data_rdata_i;
                            split_q <= 1'b1;
                            state_q <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (data_gnt_i) state_q <= WAIT_RVALID;
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        rdata_out_q <= aligned;
                        resp_q      <= 1'b1;
                        load_err_q  <= data_err_i & ~we_q;
                        store_err_q <= data_err_i & we_q;
                        hold_q      <= 1'b1;
                        split_q     <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_split_ctrl.sv
// Directed bench for lsu_split_ctrl: aligned, split, stalled, error and
// reset-abandon accesses with hand-computed bus and result values.
module tb_lsu_split_ctrl;
    import lsu_split_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    data_type_e  dtype;
    logic        sx;
    logic [31:0] wdata;
    logic [31:0] adder;
    logic        incr;
    logic        dreq;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] addr;
    logic        dwe;
    logic [3:0]  be;
    logic [31:0] dwdata;
    logic [31:0] rdata;
    logic [31:0] lrdata;
    logic        resp;
    logic        lerr;
    logic        serr;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_split_ctrl dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .lsu_req_i           (req),
        .lsu_we_i            (we),
        .lsu_type_i          (dtype),
        .lsu_sign_ext_i      (sx),
        .lsu_wdata_i         (wdata),
        .adder_result_ex_i   (adder),
        .lsu_addr_incr_req_o (incr),
        .data_req_o          (dreq),
        .data_gnt_i          (gnt),
        .data_rvalid_i       (rvalid),
        .data_err_i          (err),
        .data_addr_o         (addr),
        .data_we_o           (dwe),
        .data_be_o           (be),
        .data_wdata_o        (dwdata),
        .data_rdata_i        (rdata),
        .lsu_rdata_o         (lrdata),
        .lsu_resp_valid_o    (resp),
        .load_err_o          (lerr),
        .store_err_o         (serr),
        .lsu_busy_o          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic w, input data_type_e t, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic g);
        req   = 1'b1;
        we    = w;
        dtype = t;
        sx    = s;
        adder = a;
        wdata = d;
        gnt   = g;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; dtype = WORD; sx = 1'b0;
        wdata = '0; adder = '0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
        rdata = '0;

        // reset and the cycle after it
        tick(); req = 1'b1; settle();
        chk("rst_req", dreq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp", resp, 0);
        chk("rst_incr", incr, 0);
        tick(); rst = 1'b0; settle();
        chk("post_rst_req", dreq, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_resp", resp, 0);
        chk("post_rst_lerr", lerr, 0);
        chk("post_rst_serr", serr, 0);
        req = 1'b0; tick();

        // LW 0x100 aligned
        start(0, WORD, 0, 32'h100, 0, 1); settle();
        chk("lw_req", dreq, 1);
        chk("lw_addr", addr, 32'h100);
        chk("lw_be", be, 4'b1111);
        chk("lw_we", dwe, 0);
        tick(); gnt = 0; rvalid = 1; rdata = 32'hDEADBEEF; settle();
        chk("lw_busy", busy, 1);
        chk("lw_req_wait", dreq, 0);
        chk("lw_resp_early", resp, 0);
        tick(); rvalid = 0; settle();
        chk("lw_resp", resp, 1);
        chk("lw_rdata", lrdata, 32'hDEADBEEF);
        chk("lw_lerr", lerr, 0);
        chk("lw_no_b2b", dreq, 0);
        req = 0; tick(); settle();
        chk("lw_resp_once", resp, 0);

        // LW 0x101 split
        start(0, WORD, 0, 32'h101, 0, 1); settle();
        chk("mis_be0", be, 4'b1110);
        chk("mis_addr0", addr, 32'h100);
        chk("mis_incr0", incr, 0);
        tick(); gnt = 0; rvalid = 1; rdata = 32'h44332211; settle();
        chk("mis_req_wait", dreq, 0);
        tick(); rvalid = 0; adder = 32'h105; gnt = 1; settle();
        chk("mis_incr1", incr, 1);
        chk("mis_req1", dreq, 1);
        chk("mis_addr1", addr, 32'h104);
        chk("mis_be1", be, 4'b0001);
        tick(); gnt = 0; rvalid = 1; rdata = 32'h88776655; settle();
        chk("mis_incr_off", incr, 0);
        chk("mis_busy", busy, 1);
        tick(); rvalid = 0; settle();
        chk("mis_resp", resp, 1);
        chk("mis_rdata", lrdata, 32'h55443322);
        req = 0; tick();

        // LH signed 0x203 split
        start(0, HALF, 1, 32'h203, 0, 1); settle();
        chk("lh_be0", be, 4'b1000);
        chk("lh_addr0", addr, 32'h200);
        tick(); gnt = 0; rvalid = 1; rdata = 32'h80123456; settle();
        tick(); rvalid = 0; adder = 32'h207; gnt = 1; settle();
        chk("lh_be1", be, 4'b0001);
        chk("lh_addr1", addr, 32'h204);
        chk("lh_incr", incr, 1);
        tick(); gnt = 0; rvalid = 1; rdata = 32'h123456F0; settle();
        tick(); rvalid = 0; settle();
        chk("lh_resp", resp, 1);
        chk("lh_rdata", lrdata, 32'hFFFFF080);
        req = 0; tick();

        // SB 0x302, grant withheld three cycles
        start(1, BYTE, 0, 32'h302, 32'h000000AB, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) gnt = 1;
            settle();
            chk("sb_req", dreq, 1);
            chk("sb_addr", addr, 32'h300);
            chk("sb_be", be, 4'b0100);
            chk("sb_wdata", dwdata, 32'h00AB0000);
            chk("sb_we", dwe, 1);
            tick();
        end
        gnt = 0; rvalid = 1; settle();
        tick(); rvalid = 0; settle();
        chk("sb_resp", resp, 1);
        chk("sb_serr", serr, 0);
        chk("sb_lerr", lerr, 0);
        req = 0; tick();

        // SW 0x102 split, error on phase 2
        start(1, WORD, 0, 32'h102, 32'h11223344, 1); settle();
        chk("sw_be0", be, 4'b1100);
        chk("sw_wdata0", dwdata, 32'h33441122);
        tick(); gnt = 0; rvalid = 1; settle();
        tick(); rvalid = 0; adder = 32'h106; gnt = 1; settle();
        chk("sw_be1", be, 4'b0011);
        chk("sw_wdata1", dwdata, 32'h33441122);
        chk("sw_addr1", addr, 32'h104);
        tick(); gnt = 0; rvalid = 1; err = 1; settle();
        tick(); rvalid = 0; err = 0; settle();
        chk("sw_resp", resp, 1);
        chk("sw_serr", serr, 1);
        chk("sw_lerr", lerr, 0);
        req = 0; tick();

        // LHU 0x202 aligned halfword
        start(0, HALF, 0, 32'h202, 0, 1); settle();
        chk("lhu_be", be, 4'b1100);
        tick(); gnt = 0; rvalid = 1; rdata = 32'hBEEF1234; settle();
        tick(); rvalid = 0; settle();
        chk("lhu_resp", resp, 1);
        chk("lhu_rdata", lrdata, 32'h0000BEEF);
        req = 0; tick();

        // split LW, error on phase 1
        start(0, WORD, 0, 32'h101, 0, 1); settle();
        tick(); gnt = 0; rvalid = 1; err = 1; settle();
        tick(); rvalid = 0; err = 0; settle();
        chk("err_resp", resp, 1);
        chk("err_lerr", lerr, 1);
        chk("err_serr", serr, 0);
        chk("err_no_p2_req", dreq, 0);
        chk("err_incr", incr, 0);
        chk("err_busy", busy, 0);
        req = 0; tick(); settle();
        chk("err_resp_once", resp, 0);
        chk("err_busy_after", busy, 0);

        // reset in WAIT_RVALID_MIS, then a stale rvalid
        start(0, WORD, 0, 32'h101, 0, 1); settle();
        tick(); gnt = 0; rst = 1; settle();
        chk("rr_busy_pre", busy, 1);
        tick(); settle();
        chk("rr_busy", busy, 0);
        chk("rr_req", dreq, 0);
        chk("rr_resp", resp, 0);
        rst = 0; req = 0; rvalid = 1; rdata = 32'hCAFEF00D; settle();
        chk("rr_stale_req", dreq, 0);
        tick(); rvalid = 0; settle();
        chk("rr_stale_resp", resp, 0);
        chk("rr_stale_busy", busy, 0);
        chk("rr_stale_lerr", lerr, 0);
        tick(); settle();
        chk("rr_final_resp", resp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
